// File: rtl/factor_search_ctrl.sv
// Factor search controller: enumerates a<=b operand pairs, multiplies each with a
// shift-add datapath and compares against the target. Optional macro: FACTOR_SEARCH_PRUNE_EN.
module factor_search_ctrl #(
    parameter int W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [2*W-1:0] target,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [W-1:0]   factor_a,
    output logic [W-1:0]   factor_b,
    output logic [2*W-1:0] trials
);

    localparam int TW = 2 * W;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] OP_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MUL,
        S_CMP,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tgt_q, tgt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [TW-1:0]  prod_q, prod_d;
    logic [TW-1:0]  mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           found_q, found_d;
    logic [W-1:0]   fa_q, fa_d;
    logic [W-1:0]   fb_q, fb_d;
    logic [TW-1:0]  trials_q, trials_d;
    logic           done_q, done_d;

    logic           load;
    logic [W-1:0]   a_new;
    logic [W-1:0]   b_new;

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        found_d  = found_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        trials_d = trials_q;
        done_d   = (state_q == S_DONE);
        load     = 1'b0;
        a_new    = a_q;
        b_new    = b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tgt_d    = target;
                    found_d  = 1'b0;
                    fa_d     = '0;
                    fb_d     = '0;
                    trials_d = '0;
                    state_d  = S_INIT;
                end
            end
            S_INIT: begin
                if (tgt_q < TW'(4)) begin
                    state_d = S_DONE;
                end else begin
                    a_new   = W'(2);
                    b_new   = W'(2);
                    load    = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                trials_d = trials_q + 1'b1;
                if (prod_q == tgt_q) begin
                    found_d = 1'b1;
                    fa_d    = a_q;
                    fb_d    = b_q;
                    state_d = S_DONE;
                end else
`ifdef FACTOR_SEARCH_PRUNE_EN
                // Products only grow along b, so an overshoot ends this row; a
                // diagonal overshoot means every later row overshoots as well.
                if (prod_q > tgt_q) begin
                    if (b_q == a_q || a_q == OP_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        a_new   = a_q + 1'b1;
                        b_new   = a_q + 1'b1;
                        load    = 1'b1;
                        state_d = S_MUL;
                    end
                end else
`endif
                if (b_q == OP_MAX) begin
                    if (a_q == OP_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        a_new   = a_q + 1'b1;
                        b_new   = a_q + 1'b1;
                        load    = 1'b1;
                        state_d = S_MUL;
                    end
                end else begin
                    b_new   = b_q + 1'b1;
                    load    = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            a_d      = a_new;
            b_d      = b_new;
            prod_d   = '0;
            mcand_d  = {{W{1'b0}}, a_new};
            mplier_d = b_new;
            cnt_d    = CW'(W - 1);
        end

        if (abort && (state_q == S_INIT || state_q == S_MUL || state_q == S_CMP)) begin
            state_d  = S_IDLE;
            found_d  = 1'b0;
            fa_d     = '0;
            fb_d     = '0;
            trials_d = trials_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tgt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            found_q  <= 1'b0;
            fa_q     <= '0;
            fb_q     <= '0;
            trials_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            found_q  <= found_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            trials_q <= trials_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == S_INIT) || (state_q == S_MUL) || (state_q == S_CMP);
    assign done     = done_q;
    assign found    = found_q;
    assign factor_a = fa_q;
    assign factor_b = fb_q;
    assign trials   = trials_q;

endmodule
